riv_mem_arbiter: RTL and testbench

Single-port memory arbiter between the IF-stage instruction fetch port and the MEM-stage load/store port of the five-stage pipeline. It sits between both pipeline stages and one unified 64-bit memory. It serialises their requests with one transaction outstanding at a time, and gives data accesses priority with a bounded-starvation guarantee for fetch. It also routes each response back to its owner and discards fetch responses invalidated by a taken branch/jump.

---
 rtl/riv_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_riv_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riv_mem_arbiter.sv
// riv_mem_arbiter
// Single-port memory arbiter between the IF-stage fetch port and the
// MEM-stage load/store port. One transaction is outstanding at a time.
// Data requests normally win. A waiting fetch is guaranteed a grant after
// STARVE_MAX consecutive data grants. Fetch responses that a taken
// branch/jump has invalidated are discarded.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_if_req/i_if_addr         fetch request (held until o_if_gnt)
//   o_if_gnt                   fetch accepted this cycle
//   o_if_rvalid/o_if_rdata     fetch instruction word return
//   i_flush                    kill any granted, unreturned fetch
//   i_dm_req/_we/_be/_addr/_wdata  data request (held until o_dm_gnt)
//   o_dm_gnt                   data accepted this cycle
//   o_dm_rvalid/o_dm_rdata     load data / store acknowledge
//   o_mem_req/_we/_be/_addr/_wdata  registered memory request
//   i_mem_gnt                  memory accepted the request
//   i_mem_rvalid/i_mem_rdata   memory response, one per accepted request
module riv_mem_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_flush,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [7:0]        i_dm_be,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [63:0]       i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic [63:0]       o_dm_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_be,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [63:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [63:0]       i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP
  } state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_starve_cnt;
  logic       r_kill;
  logic       r_word_sel;
  logic       r_owner_if;

  logic       w_arb;
  logic       w_rsp;
  logic       w_if_win;
  logic       w_dm_win;

  // Arbitration happens in IDLE, or in RSP on the cycle the response lands,
  // so back-to-back transactions need no idle cycle in between.
  always_comb begin
    w_rsp    = (r_state == S_RSP) && i_mem_rvalid;
    w_arb    = (r_state == S_IDLE) || w_rsp;
    w_if_win = w_arb && i_if_req && (!i_dm_req || (r_starve_cnt == LP_STARVE_MAX));
    w_dm_win = w_arb && i_dm_req && !w_if_win;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_if_win || w_dm_win) w_state_nxt = S_REQ;
      S_REQ:   if (i_mem_gnt) w_state_nxt = S_RSP;
      S_RSP:   if (i_mem_rvalid) w_state_nxt = (w_if_win || w_dm_win) ? S_REQ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grants are forced low while reset is held so every output reads 0.
  always_comb begin
    o_if_gnt    = rst_n && w_if_win;
    o_dm_gnt    = rst_n && w_dm_win;
    o_dm_rvalid = w_rsp && !r_owner_if;
    o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;
    // A flush coinciding with the response also drops it.
    o_if_rvalid = w_rsp && r_owner_if && !r_kill && !i_flush;
    o_if_rdata  = '0;
    if (o_if_rvalid) begin
      o_if_rdata = r_word_sel ? i_mem_rdata[63:32] : i_mem_rdata[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_kill       <= 1'b0;
      r_word_sel   <= 1'b0;
      r_owner_if   <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_be     <= '0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_if_win) begin
        r_owner_if   <= 1'b1;
        // A flush on the grant cycle already invalidates this fetch.
        r_kill       <= i_flush;
        r_word_sel   <= i_if_addr[2];
        r_starve_cnt <= '0;
        o_mem_req    <= 1'b1;
        o_mem_we     <= 1'b0;
        o_mem_be     <= '1;
        o_mem_addr   <= i_if_addr;
        o_mem_wdata  <= '0;
      end else if (w_dm_win) begin
        r_owner_if  <= 1'b0;
        r_kill      <= 1'b0;
        if (!i_if_req) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt < LP_STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
        o_mem_req   <= 1'b1;
        o_mem_we    <= i_dm_we;
        o_mem_be    <= i_dm_be;
        o_mem_addr  <= i_dm_addr;
        o_mem_wdata <= i_dm_wdata;
      end else if (w_arb) begin
        r_kill    <= 1'b0;
        o_mem_req <= 1'b0;
      end else begin
        // Only REQ, or RSP still waiting for data, reach this branch.
        if ((r_state == S_REQ) && i_mem_gnt) begin
          o_mem_req <= 1'b0;
        end
        if (r_owner_if && i_flush) begin
          r_kill <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_riv_mem_arbiter.sv
module tb_riv_mem_arbiter;

  localparam int unsigned AW   = 64;
  localparam int unsigned SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [31:0]   o_if_rdata;
  logic          i_flush;
  logic          i_dm_req;
  logic          i_dm_we;
  logic [7:0]    i_dm_be;
  logic [AW-1:0] i_dm_addr;
  logic [63:0]   i_dm_wdata;
  logic          o_dm_gnt;
  logic          o_dm_rvalid;
  logic [63:0]   o_dm_rdata;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [7:0]    o_mem_be;
  logic [AW-1:0] o_mem_addr;
  logic [63:0]   o_mem_wdata;
  logic          i_mem_gnt;
  logic          i_mem_rvalid;
  logic [63:0]   i_mem_rdata;

  riv_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata), .i_flush(i_flush),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_be(i_dm_be),
    .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata), .o_dm_gnt(o_dm_gnt),
    .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one transaction record plus the fairness counter.
  bit          m_busy, m_acc, m_own_if, m_kill, m_wsel;
  int unsigned m_starve;
  logic        m_req, m_we;
  logic [7:0]  m_be;
  logic [63:0] m_addr, m_wdata;
  bit          p_fwin, p_dwin;

  // Observed DUT outputs of the last checked cycle.
  logic        obs_if_gnt, obs_dm_gnt, obs_ifv, obs_dmv, obs_mreq, obs_mwe;
  logic [31:0] obs_ifd;
  logic [63:0] obs_dmd;
  logic [7:0]  obs_mbe;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_own_if = 0; m_kill = 0; m_wsel = 0; m_starve = 0;
    m_req = 0; m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
    p_fwin = 0; p_dwin = 0;
  endtask

  task automatic idle_inputs();
    i_if_req = 0; i_if_addr = '0; i_flush = 0;
    i_dm_req = 0; i_dm_we = 0; i_dm_be = '0; i_dm_addr = '0; i_dm_wdata = '0;
    i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"}, o_if_gnt, 0);
    chk({tag, "_dm_gnt"}, o_dm_gnt, 0);
    chk({tag, "_if_rv"}, o_if_rvalid, 0);
    chk({tag, "_if_rd"}, o_if_rdata, 0);
    chk({tag, "_dm_rv"}, o_dm_rvalid, 0);
    chk({tag, "_dm_rd"}, o_dm_rdata, 0);
    chk({tag, "_mreq"}, o_mem_req, 0);
    chk({tag, "_mwe"}, o_mem_we, 0);
    chk({tag, "_mbe"}, o_mem_be, 0);
    chk({tag, "_maddr"}, o_mem_addr, 0);
    chk({tag, "_mwd"}, o_mem_wdata, 0);
  endtask

  // Called after inputs for the cycle are applied; checks then advances model.
  task automatic check_cycle();
    bit free, resp, fwin, dwin, e_ifv, e_dmv;
    logic [63:0] e_ifd, e_dmd;
    #2;
    free  = !m_busy || (m_acc && i_mem_rvalid);
    resp  = m_busy && m_acc && i_mem_rvalid;
    e_dmv = resp && !m_own_if;
    e_dmd = e_dmv ? i_mem_rdata : 64'd0;
    e_ifv = resp && m_own_if && !m_kill && !i_flush;
    e_ifd = e_ifv ? (m_wsel ? {32'd0, i_mem_rdata[63:32]} : {32'd0, i_mem_rdata[31:0]}) : 64'd0;
    fwin  = free && i_if_req && (!i_dm_req || m_starve == SMAX);
    dwin  = free && i_dm_req && !fwin;

    chk("if_gnt", o_if_gnt, fwin);
    chk("dm_gnt", o_dm_gnt, dwin);
    chk("if_rvalid", o_if_rvalid, e_ifv);
    chk("if_rdata", o_if_rdata, e_ifd);
    chk("dm_rvalid", o_dm_rvalid, e_dmv);
    chk("dm_rdata", o_dm_rdata, e_dmd);
    chk("mem_req", o_mem_req, m_req);
    chk("mem_we", o_mem_we, m_we);
    chk("mem_be", o_mem_be, m_be);
    chk("mem_addr", o_mem_addr, m_addr);
    chk("mem_wdata", o_mem_wdata, m_wdata);

    obs_if_gnt = o_if_gnt; obs_dm_gnt = o_dm_gnt;
    obs_ifv = o_if_rvalid; obs_ifd = o_if_rdata;
    obs_dmv = o_dm_rvalid; obs_dmd = o_dm_rdata;
    obs_mreq = o_mem_req; obs_mwe = o_mem_we; obs_mbe = o_mem_be;

    if (fwin) begin
      m_busy = 1; m_acc = 0; m_own_if = 1; m_kill = i_flush; m_wsel = i_if_addr[2];
      m_starve = 0;
      m_req = 1; m_we = 0; m_be = 8'hFF; m_addr = i_if_addr; m_wdata = '0;
    end else if (dwin) begin
      m_busy = 1; m_acc = 0; m_own_if = 0; m_kill = 0;
      m_starve = i_if_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
      m_req = 1; m_we = i_dm_we; m_be = i_dm_be; m_addr = i_dm_addr; m_wdata = i_dm_wdata;
    end else if (free) begin
      m_busy = 0; m_kill = 0; m_req = 0;
    end else begin
      if (!m_acc && i_mem_gnt) begin
        m_acc = 1; m_req = 0;
      end
      if (m_own_if && i_flush) m_kill = 1;
    end
    p_fwin = fwin; p_dwin = dwin;
  endtask

  // Four-cycle transaction from IDLE: request, mem gnt, optional flush, rvalid.
  task automatic txn(input bit is_if, input logic [63:0] addr, input bit we,
                     input logic [7:0] be, input logic [63:0] wd, input logic [63:0] rd,
                     input bit fl, output logic g, output logic mreq1, output logic mreq2,
                     output logic we1, output logic [7:0] be1,
                     output logic rv, output logic [63:0] d);
    tick(); idle_inputs();
    if (is_if) begin i_if_req = 1; i_if_addr = addr; end
    else begin
      i_dm_req = 1; i_dm_we = we; i_dm_be = be; i_dm_addr = addr; i_dm_wdata = wd;
    end
    check_cycle();
    g = is_if ? obs_if_gnt : obs_dm_gnt;
    tick(); idle_inputs(); i_mem_gnt = 1; check_cycle();
    mreq1 = obs_mreq; we1 = obs_mwe; be1 = obs_mbe;
    tick(); idle_inputs(); i_flush = fl; check_cycle();
    mreq2 = obs_mreq;
    tick(); idle_inputs(); i_mem_rvalid = 1; i_mem_rdata = rd; check_cycle();
    rv = is_if ? obs_ifv : obs_dmv;
    d  = is_if ? {32'd0, obs_ifd} : obs_dmd;
  endtask

  logic        g, mr1, mr2, we1, rv;
  logic [7:0]  be1;
  logic [63:0] d;
  logic [9:0]  order;
  int unsigned ngr;

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    #12;
    chk_all_zero("reset");
    tick(); rst_n = 1;

    txn(0, 64'h100, 0, 8'hFF, 0, 64'hDEADBEEF_CAFEF00D, 0, g, mr1, mr2, we1, be1, rv, d);
    chk("load_gnt_c0", g, 1);
    chk("load_mreq_c1", mr1, 1);
    chk("load_mreq_c2", mr2, 0);
    chk("load_rvalid_c3", rv, 1);
    chk("load_rdata_c3", d, 64'hDEADBEEF_CAFEF00D);

    txn(1, 64'h104, 0, 0, 0, 64'h11111111_22222222, 0, g, mr1, mr2, we1, be1, rv, d);
    chk("fetch104_rv", rv, 1);
    chk("fetch104_rd", d, 64'h11111111);
    txn(1, 64'h100, 0, 0, 0, 64'h11111111_22222222, 0, g, mr1, mr2, we1, be1, rv, d);
    chk("fetch100_rd", d, 64'h22222222);
    chk("fetch_be", be1, 8'hFF);

    txn(0, 64'h208, 1, 8'h0F, 64'h0123456789ABCDEF, 64'd0, 0, g, mr1, mr2, we1, be1, rv, d);
    chk("store_we", we1, 1);
    chk("store_be", be1, 8'h0F);
    chk("store_ack", rv, 1);
    chk("store_rdata", d, 0);

    txn(1, 64'h100, 0, 0, 0, 64'hAAAAAAAA_BBBBBBBB, 1, g, mr1, mr2, we1, be1, rv, d);
    chk("flush_rv", rv, 0);
    txn(1, 64'h104, 0, 0, 0, 64'hCCCCCCCC_DDDDDDDD, 0, g, mr1, mr2, we1, be1, rv, d);
    chk("postflush_gnt", g, 1);
    chk("postflush_rv", rv, 1);
    chk("postflush_rd", d, 64'hCCCCCCCC);

    // Reset while a load is in RSP.
    tick(); idle_inputs(); i_dm_req = 1; i_dm_addr = 64'h40; check_cycle();
    tick(); idle_inputs(); i_mem_gnt = 1; check_cycle();
    tick(); idle_inputs();
    i_if_req = 1; i_dm_req = 1; i_mem_rvalid = 1; i_mem_rdata = 64'h5555;
    rst_n = 0;
    #1;
    chk_all_zero("rst_in_rsp");
    model_reset();
    tick(); idle_inputs(); rst_n = 1;
    check_cycle();
    tick(); idle_inputs(); i_dm_req = 1; i_dm_addr = 64'h48; check_cycle();
    chk("rst_regrant", obs_dm_gnt, 1);
    tick(); idle_inputs(); i_mem_gnt = 1; check_cycle();
    tick(); idle_inputs(); i_mem_rvalid = 1; check_cycle();

    // Starvation: both requesters held, zero-wait memory.
    order = '0; ngr = 0;
    for (int c = 0; c < 40 && ngr < 10; c++) begin
      tick(); idle_inputs();
      i_if_req = 1; i_if_addr = 64'h200;
      i_dm_req = 1; i_dm_addr = 64'h300;
      i_mem_gnt = 1; i_mem_rvalid = 1; i_mem_rdata = {$urandom, $urandom};
      check_cycle();
      if (obs_if_gnt || obs_dm_gnt) begin
        order[ngr] = obs_if_gnt;
        ngr++;
      end
    end
    chk("starve_grants", ngr, 10);
    chk("starve_order", order, 10'h210);

    // Randomized traffic with a protocol-correct requester driver.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!(i_if_req && !p_fwin)) begin
        i_if_req  = ($urandom_range(0, 2) == 0);
        i_if_addr = {$urandom, $urandom} & ~64'h3;
      end
      if (!(i_dm_req && !p_dwin)) begin
        i_dm_req   = ($urandom_range(0, 2) == 0);
        i_dm_we    = $urandom_range(0, 1);
        i_dm_be    = 8'($urandom);
        i_dm_addr  = {$urandom, $urandom};
        i_dm_wdata = {$urandom, $urandom};
      end
      i_flush      = ($urandom_range(0, 7) == 0);
      i_mem_gnt    = ($urandom_range(0, 2) != 0);
      i_mem_rvalid = ($urandom_range(0, 2) != 0);
      i_mem_rdata  = {$urandom, $urandom};
      check_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
